// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: queues ALU commands, issues them one at a time
// and returns tagged results with a div/mod-by-zero flag.
module alu_cmd_issuer #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_select,
  input  logic [W:0]   alu_out,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W:0]   rsp_data,
  output logic [2:0]   rsp_op,
  output logic [3:0]   rsp_tag,
  output logic         rsp_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 3 + 2 * W + 4;
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [3:0]    tag_q, tag_d;
  state_t        state_q, state_d;

  logic [W-1:0]  alu_a_q, alu_a_d;
  logic [W-1:0]  alu_b_q, alu_b_d;
  logic [2:0]    sel_q, sel_d;
  logic [3:0]    pend_tag_q, pend_tag_d;
  logic [2:0]    pend_op_q, pend_op_d;

  logic          rsp_valid_q, rsp_valid_d;
  logic [W:0]    rsp_data_q, rsp_data_d;
  logic [2:0]    rsp_op_q, rsp_op_d;
  logic [3:0]    rsp_tag_q, rsp_tag_d;
  logic          rsp_err_q, rsp_err_d;

  logic          push, pop, empty, err;
  logic [2:0]    head_op;
  logic [W-1:0]  head_a, head_b;
  logic [3:0]    head_tag;

  assign cmd_ready = count_q != FULL;
  assign empty     = count_q == '0;
  assign push      = cmd_valid && cmd_ready;
  assign {head_op, head_a, head_b, head_tag} = mem_q[rd_ptr_q];

  // judged on what was issued, never on the ALU's own output
  assign err = (sel_q == 3'b011 || sel_q == 3'b100) && alu_b_q == '0;

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_select = sel_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_op     = rsp_op_q;
  assign rsp_tag    = rsp_tag_q;
  assign rsp_err    = rsp_err_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_a, cmd_b, tag_q};
  end

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    sel_d       = sel_q;
    pend_tag_d  = pend_tag_q;
    pend_op_d   = pend_op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_op_d    = rsp_op_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        rsp_data_d  = err ? '0 : alu_out;
        rsp_op_d    = pend_op_q;
        rsp_tag_d   = pend_tag_q;
        rsp_err_d   = err;
        rsp_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (!empty) begin
            pop     = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      alu_a_d    = head_a;
      alu_b_d    = head_b;
      sel_d      = head_op;
      pend_op_d  = head_op;
      pend_tag_d = head_tag;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    tag_d    = push ? tag_q + 4'd1 : tag_q;
    count_d  = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tag_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      sel_q       <= '0;
      pend_tag_q  <= '0;
      pend_op_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_op_q    <= '0;
      rsp_tag_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      tag_q       <= tag_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      sel_q       <= sel_d;
      pend_tag_q  <= pend_tag_d;
      pend_op_q   <= pend_op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_op_q    <= rsp_op_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_err_q   <= rsp_err_d;
    end
  end
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: scoreboard bench for alu_cmd_issuer with a
// behavioural ALU attached to the issue ports.
module tb_alu_cmd_issuer;
  localparam int W = 4;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [W-1:0] cmd_a, cmd_b;
  logic [W-1:0] alu_a, alu_b;
  logic [2:0]   alu_select;
  logic [W:0]   alu_out;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W:0]   rsp_data;
  logic [2:0]   rsp_op;
  logic [3:0]   rsp_tag;
  logic         rsp_err;

  alu_cmd_issuer #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select),
    .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_op(rsp_op),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Reference ALU in plain integer arithmetic; div/mod by zero give 31
  function automatic logic [4:0] alu_ref(input logic [2:0] op,
                                         input logic [3:0] a,
                                         input logic [3:0] b);
    int ia, ib, r;
    ia = int'(a);
    ib = int'(b);
    case (op)
      3'd0: r = ia;
      3'd1: r = ia + ib;
      3'd2: r = ia - ib;
      3'd3: r = (ib == 0) ? 31 : ia / ib;
      3'd4: r = (ib == 0) ? 31 : ia % ib;
      3'd5: r = ia * (2 ** ib);
      3'd6: r = ia / (2 ** ib);
      default: r = (ia > ib) ? 1 : 0;
    endcase
    return 5'(r & 31);
  endfunction

  assign alu_out = alu_ref(alu_select, alu_a, alu_b);

  typedef struct packed {
    logic [4:0] data;
    logic [2:0] op;
    logic [3:0] tag;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   hs_cyc[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   model_tag = 0;
  int   last_tag = -1;
  bit   rr_en = 0;
  bit   held = 0;
  logic [12:0] prev;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // acceptance recorder: expected response pushed when a command is taken
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      model_tag = 0;
    end else if (cmd_valid && cmd_ready) begin
      exp_t e;
      e.err  = (cmd_op == 3'd3 || cmd_op == 3'd4) && cmd_b == 0;
      e.data = e.err ? 5'd0 : alu_ref(cmd_op, cmd_a, cmd_b);
      e.op   = cmd_op;
      e.tag  = 4'(model_tag);
      exp_q.push_back(e);
      model_tag = (model_tag + 1) % 16;
    end
  end

  // response monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 0;
    end else if (rsp_valid) begin
      if (held) chk("hold_stable", {rsp_data, rsp_op, rsp_tag, rsp_err}, prev);
      if (rsp_ready) begin
        held = 0;
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_op", rsp_op, e.op);
          chk("rsp_tag", rsp_tag, e.tag);
          chk("rsp_err", rsp_err, e.err);
          last_tag = rsp_tag;
          hs_cyc.push_back(cyc);
        end
      end else begin
        held = 1;
        prev = {rsp_data, rsp_op, rsp_tag, rsp_err};
      end
    end else begin
      held = 0;
    end
  end

  always @(posedge clk) begin
    if (rr_en) begin
      #1;
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [2:0] op, input logic [3:0] a,
                      input logic [3:0] b, input int bound, output bit acc);
    int n;
    n = 0;
    acc = 0;
    cmd_valid = 1;
    cmd_op = op;
    cmd_a = a;
    cmd_b = b;
    while (!acc && n < bound) begin
      @(negedge clk);
      acc = cmd_ready;
      n++;
      @(posedge clk);
      #1;
    end
    cmd_valid = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", int'(n < 300), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_alu_a"}, alu_a, 0);
    chk({nm, "_alu_b"}, alu_b, 0);
    chk({nm, "_alu_sel"}, alu_select, 0);
    chk({nm, "_rsp_valid"}, rsp_valid, 0);
    chk({nm, "_rsp_data"}, rsp_data, 0);
    chk({nm, "_rsp_op"}, rsp_op, 0);
    chk({nm, "_rsp_tag"}, rsp_tag, 0);
    chk({nm, "_rsp_err"}, rsp_err, 0);
    chk({nm, "_cmd_ready"}, cmd_ready, 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    bit acc;
    int n, h0, k;
    logic [2:0] op6;
    logic [3:0] a6, b6;
    rst_n = 0;
    cmd_valid = 0;
    cmd_op = 0;
    cmd_a = 0;
    cmd_b = 0;
    rsp_ready = 0;
    #2;
    chk_zero("reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    rsp_ready = 1;

    // single add: latency and value
    send(3'd1, 4'd9, 4'd8, 20, acc);
    chk("accept_add", int'(acc), 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 10);
    chk("latency", n, 3);
    chk("first_data", rsp_data, 17);
    chk("first_tag", rsp_tag, 0);
    drain();

    // divide and modulo by zero, then a normal divide
    send(3'd3, 4'd7, 4'd0, 20, acc);
    send(3'd4, 4'd7, 4'd0, 20, acc);
    send(3'd3, 4'd7, 4'd2, 20, acc);
    send(3'd1, 4'd5, 4'd0, 20, acc);
    drain();

    // backpressure: five accepted, sixth blocked
    do_reset();
    rsp_ready = 0;
    for (int i = 0; i < 5; i++) begin
      send(3'($urandom), 4'($urandom), 4'($urandom), 5, acc);
      chk("fill_accept", int'(acc), 1);
    end
    op6 = 3'd2;
    a6 = 4'd3;
    b6 = 4'd9;
    cmd_valid = 1;
    cmd_op = op6;
    cmd_a = a6;
    cmd_b = b6;
    repeat (3) begin
      @(negedge clk);
      chk("full_cmd_ready", cmd_ready, 0);
    end
    chk("held_valid", rsp_valid, 1);
    chk("held_tag", rsp_tag, 0);
    h0 = hs_cyc.size();
    @(posedge clk);
    #1;
    rsp_ready = 1;
    send(op6, a6, b6, 20, acc);
    chk("sixth_accept", int'(acc), 1);
    drain();
    chk("drain_count", hs_cyc.size() - h0, 6);
    if (hs_cyc.size() - h0 == 6) begin
      for (int i = h0 + 1; i < h0 + 6; i++)
        chk("rsp_spacing", hs_cyc[i] - hs_cyc[i-1], 2);
    end
    chk("sixth_tag", last_tag, 5);

    // random traffic with random backpressure, tags wrap
    do_reset();
    rr_en = 1;
    for (int i = 0; i < 40; i++) begin
      send(3'($urandom), 4'($urandom), 4'($urandom_range(0, 15)), 100, acc);
      chk("rand_accept", int'(acc), 1);
      k = $urandom_range(0, 2);
      repeat (k) begin
        @(posedge clk);
        #1;
      end
    end
    rr_en = 0;
    @(posedge clk);
    #1;
    rsp_ready = 1;
    drain();
    chk("rand_last_tag", last_tag, 39 % 16);

    // reset while ISSUE with three queued
    rsp_ready = 0;
    for (int i = 0; i < 5; i++) begin
      send(3'd1, 4'(i), 4'd1, 5, acc);
      chk("pre_reset_accept", int'(acc), 1);
    end
    rsp_ready = 1;
    @(posedge clk);
    #1;
    rsp_ready = 0;
    rst_n = 0;
    #1;
    chk_zero("midreset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    rsp_ready = 1;
    repeat (8) begin
      @(negedge clk);
      chk("no_rsp_after_reset", rsp_valid, 0);
    end
    @(posedge clk);
    #1;
    send(3'd2, 4'd3, 4'd5, 20, acc);
    drain();
    chk("tag_after_reset", last_tag, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Initiator-side controller for the team's 4-bit combinational ALU (ops: pass, add, sub, div, mod, shl, shr, gt; 5-bit result).
- Accepts operation commands over a valid/ready interface and queues them in a small FIFO.
- Issues one command at a time on registered ALU input ports, then captures the ALU result one cycle later.
- Returns the result with a sequence tag and a divide/mod-by-zero error flag over a valid/ready response interface.

Parameters:
- DEPTH, 4, command FIFO entries; power of 2, minimum 2.
- W, 4, operand width; the result width is W+1.

Ports:
- clk  input  1  single clock; all logic rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  command accepted when high together with cmd_valid.
- cmd_op  input  3  ALU select code.
- cmd_a  input  W  operand a.
- cmd_b  input  W  operand b.
- alu_a  output  W  registered operand a to the ALU.
- alu_b  output  W  registered operand b to the ALU.
- alu_select  output  3  registered select to the ALU.
- alu_out  input  W+1  combinational ALU result.
- rsp_valid  output  1  response held valid until taken.
- rsp_ready  input  1  downstream accepts the response.
- rsp_data  output  W+1  captured result.
- rsp_op  output  3  op code of this response.
- rsp_tag  output  4  sequence number of this command.
- rsp_err  output  1  op was div (011) or mod (100) with b==0.

Behaviour:
- Reset: FIFO emptied; pointers, count, and tag counter cleared. alu_a, alu_b, alu_select, rsp_data, rsp_op, rsp_tag, rsp_err and rsp_valid all cleared to 0. State returns to IDLE.
- cmd_ready is combinational: it equals "FIFO not full". It reads 1 during and after reset.
- Push: on an edge with cmd_valid & cmd_ready, store {op, a, b, tag}, then increment the tag mod 16 (15 wraps to 0). Push while full is impossible.
- The FIFO uses wrapping read/write pointers and a count of 0..DEPTH.
- FSM states:
  - IDLE: FIFO non-empty -> pop the head into alu_* and the pending tag/op registers -> ISSUE.
  - ISSUE (alu_* stable for one cycle): capture into the response registers at the next edge -> HOLD.
    - rsp_data gets alu_out, or 0 when the err condition holds.
    - rsp_op and rsp_tag get the pending values.
    - rsp_err is set per the div/mod-by-zero rule.
    - rsp_valid goes to 1.
  - HOLD: on an edge with rsp_valid & rsp_ready, clear rsp_valid. Then:
    - FIFO non-empty: pop the next head into alu_* in that same edge -> ISSUE.
    - FIFO empty: -> IDLE.
  - HOLD with rsp_ready low: all rsp_* held stable.
- Latency: command accepted at edge E0 -> popped at E1 -> rsp_valid high after E2 (two cycles).
- Throughput: one response per 2 cycles at best.
- Capacity: one command can be in flight outside the FIFO, so DEPTH+1 commands are accepted before cmd_ready drops.
- alu_* hold their last issued value when IDLE or HOLD.
- Simultaneous push and pop in the same edge is legal; the count is unchanged.
- Ordering: responses are strictly in acceptance order; tags are consecutive mod 16.
- Error rule: the condition is checked on the issued op/b, not on alu_out. rsp_err=0 for every other op, including b==0 on add/sub/etc.
- Reset mid-operation: queued and in-flight commands are discarded with no response. The first command after reset carries tag 0.

Test Plan:
- Reset, then send op=001 a=9 b=8 with rsp_ready=1 -> rsp_valid 2 cycles after acceptance; rsp_data=5'b10001, rsp_tag=0, rsp_err=0.
- Send op=011 a=7 b=0, then op=100 a=7 b=0 -> two responses, each rsp_err=1 and rsp_data=0. Then op=011 a=7 b=2 -> rsp_data=3, rsp_err=0.
- Hold rsp_ready=0 and offer 6 commands back-to-back -> 5 accepted, cmd_ready=0 on the 6th. The first response is held stable with tag 0.
- Release rsp_ready=1 -> remaining responses arrive in order, tags 1..4, one every 2 cycles. The 6th command is then accepted with tag 5.
- Issue 17 commands -> tags 0..15 then 0. Every rsp_data matches a reference ALU model for random a/b/op.
- Assert rst_n=0 while in ISSUE with 3 commands queued -> all outputs 0 immediately and no further responses. After release, the next command returns tag 0.
